// File: rtl/clock_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_display_pkg
// Description : Shared types and constants for the time-of-day display:
//               FSM state encoding, 7-segment codes, field limits.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_display_pkg;

   // Conversion sequencer states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONV_SEC = 3'd1,
      CONV_MIN = 3'd2,
      CONV_HR  = 3'd3,
      UPDATE   = 3'd4
   } state_t;

   // Segment patterns {g,f,e,d,c,b,a}, written for active-low drive
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Largest legal value of each time field
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HR_MAX  = 23;

   // Shift/add-3 iterations for a 6-bit binary input
   localparam int BCD_ITER = 6;

   // Digit to active-low segment pattern; non-decimal codes show blank
   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      if (d > 4'd9) begin
         return SEG_BLANK;
      end
      return SEG_DIGIT[d];
   endfunction

endpackage : clock_display_pkg
`default_nettype wire

// File: rtl/clock_display_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble converter, 6-bit binary to two BCD
//               digits. One load cycle plus BCD_ITER shift/add-3 cycles; the
//               result is presented with the done pulse on the final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import clock_display_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [5:0] bin,
   output logic       done,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // {tens, ones, remaining binary bits}
   logic [13:0] r_shift;
   logic [2:0]  r_cnt;
   logic        r_busy;
   logic [13:0] w_adj;
   logic [13:0] w_next;
   logic        w_last;

   // One double-dabble step: add 3 to any digit >= 5, then shift left
   always_comb begin
      w_adj = r_shift;
      if (r_shift[13:10] >= 4'd5) begin
         w_adj[13:10] = r_shift[13:10] + 4'd3;
      end
      if (r_shift[9:6] >= 4'd5) begin
         w_adj[9:6] = r_shift[9:6] + 4'd3;
      end
      w_next = w_adj << 1;
   end

   assign w_last = r_busy && (r_cnt == 3'(BCD_ITER - 1));

   // Result is taken from the final step combinationally so that the whole
   // conversion, load included, occupies exactly BCD_ITER+1 cycles
   assign done = w_last;
   assign tens = w_next[13:10];
   assign ones = w_next[9:6];

   // Load on start when idle, then iterate; reset abandons work silently
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else if (!r_busy) begin
         if (start) begin
            r_shift <= {8'd0, bin};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
         end
      end else begin
         r_shift <= w_next;
         if (w_last) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 3'd1;
         end
      end
   end

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/clock_display.sv
`default_nettype none
// ============================================================================
// Module      : clock_display
// Description : Six-digit 7-segment driver for hh:mm:ss. Samples the
//               asynchronous time fields, converts a stable sample to BCD one
//               field at a time, dashes out-of-range fields and blinks the
//               settable fields in set mode.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_display
   import clock_display_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BLINK_HZ       = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hr,
   input  logic       set_mode,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic [6:0] hex4,
   output logic [6:0] hex5,
   output logic       busy
);

   localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // Pattern in output polarity
   function automatic logic [6:0] f_pol(input logic [6:0] code);
      return SEG_ACTIVE_LOW ? code : ~code;
   endfunction

   localparam logic [6:0] c_BLANK = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

   // Input capture and synchronization
   logic [16:0] r_s_cur;
   logic [16:0] r_s_prev;
   logic        r_set_meta;
   logic        r_set_sync;

   // Sequencer
   state_t      r_state;
   logic [16:0] r_work;
   logic [16:0] r_snap;
   logic        r_snap_valid;
   logic        r_start;
   logic        r_busy;
   logic [3:0]  r_sec_t, r_sec_o, r_min_t, r_min_o, r_hr_t, r_hr_o;
   logic [6:0]  r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;

   // Blink
   logic [BLINK_W-1:0] r_blink_cnt;
   logic               r_blink_on;

   // Combinational
   logic        w_stable;
   logic        w_trigger;
   logic [5:0]  w_conv_bin;
   logic        w_done;
   logic [3:0]  w_tens;
   logic [3:0]  w_ones;
   logic        w_sec_bad, w_min_bad, w_hr_bad;
   logic [6:0]  w_hex0_n, w_hex1_n, w_hex2_n, w_hex3_n, w_hex4_n, w_hex5_n;

   // Sample the asynchronous time bus every cycle; two equal samples in a
   // row mean the source is not mid-update
   always_ff @(posedge clk) begin
      r_s_cur  <= {hr, min, sec};
      r_s_prev <= r_s_cur;
   end

   // Two-flop synchronizer for set_mode
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_set_meta <= 1'b0;
         r_set_sync <= 1'b0;
      end else begin
         r_set_meta <= set_mode;
         r_set_sync <= r_set_meta;
      end
   end

   assign w_stable  = (r_s_cur == r_s_prev);
   assign w_trigger = w_stable && (!r_snap_valid || (r_s_cur != r_snap));

   // Converter input follows the field of the current CONV state; it is
   // only sampled on the start cycle
   always_comb begin
      w_conv_bin = '0;
      case (r_state)
         CONV_SEC: w_conv_bin = r_work[5:0];
         CONV_MIN: w_conv_bin = r_work[11:6];
         CONV_HR:  w_conv_bin = {1'b0, r_work[16:12]};
         default:  w_conv_bin = '0;
      endcase
   end

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (r_start),
      .bin   (w_conv_bin),
      .done  (w_done),
      .tens  (w_tens),
      .ones  (w_ones)
   );

   // Out-of-range fields are still converted, then replaced with dashes here
   assign w_sec_bad = r_work[5:0]   > 6'(SEC_MAX);
   assign w_min_bad = r_work[11:6]  > 6'(MIN_MAX);
   assign w_hr_bad  = r_work[16:12] > 5'(HR_MAX);

   assign w_hex0_n = f_pol(w_sec_bad ? SEG_DASH : seg_encode(r_sec_o));
   assign w_hex1_n = f_pol(w_sec_bad ? SEG_DASH : seg_encode(r_sec_t));
   assign w_hex2_n = f_pol(w_min_bad ? SEG_DASH : seg_encode(r_min_o));
   assign w_hex3_n = f_pol(w_min_bad ? SEG_DASH : seg_encode(r_min_t));
   assign w_hex4_n = f_pol(w_hr_bad  ? SEG_DASH : seg_encode(r_hr_o));
   assign w_hex5_n = f_pol(w_hr_bad  ? SEG_DASH : seg_encode(r_hr_t));

   // Sequencer: latch a fresh stable sample, convert sec/min/hr in turn,
   // then load all six digits at once so no partial time is ever shown
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_work       <= '0;
         r_snap       <= '0;
         r_snap_valid <= 1'b0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_sec_t      <= '0;
         r_sec_o      <= '0;
         r_min_t      <= '0;
         r_min_o      <= '0;
         r_hr_t       <= '0;
         r_hr_o       <= '0;
         r_hex0       <= c_BLANK;
         r_hex1       <= c_BLANK;
         r_hex2       <= c_BLANK;
         r_hex3       <= c_BLANK;
         r_hex4       <= c_BLANK;
         r_hex5       <= c_BLANK;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_trigger) begin
                  r_work  <= r_s_cur;
                  r_state <= CONV_SEC;
                  r_start <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            CONV_SEC: begin
               if (w_done) begin
                  r_sec_t <= w_tens;
                  r_sec_o <= w_ones;
                  r_state <= CONV_MIN;
                  r_start <= 1'b1;
               end
            end
            CONV_MIN: begin
               if (w_done) begin
                  r_min_t <= w_tens;
                  r_min_o <= w_ones;
                  r_state <= CONV_HR;
                  r_start <= 1'b1;
               end
            end
            CONV_HR: begin
               if (w_done) begin
                  r_hr_t  <= w_tens;
                  r_hr_o  <= w_ones;
                  r_state <= UPDATE;
               end
            end
            UPDATE: begin
               r_hex0       <= w_hex0_n;
               r_hex1       <= w_hex1_n;
               r_hex2       <= w_hex2_n;
               r_hex3       <= w_hex3_n;
               r_hex4       <= w_hex4_n;
               r_hex5       <= w_hex5_n;
               r_snap       <= r_work;
               r_snap_valid <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Blink timebase: half-period counter that toggles the phase on wrap,
   // parked in the visible phase whenever set mode is off
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (!r_set_sync) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         r_blink_cnt <= '0;
         r_blink_on  <= ~r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
      end
   end

   // Seconds are never blanked; hours and minutes blank in the off phase
   assign hex0 = r_hex0;
   assign hex1 = r_hex1;
   assign hex2 = r_blink_on ? r_hex2 : c_BLANK;
   assign hex3 = r_blink_on ? r_hex3 : c_BLANK;
   assign hex4 = r_blink_on ? r_hex4 : c_BLANK;
   assign hex5 = r_blink_on ? r_hex5 : c_BLANK;
   assign busy = r_busy;

endmodule : clock_display
`default_nettype wire

// File: tb/tb_clock_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_display
// Description : Scoreboard bench for clock_display. Stimulus pushes the
//               expected six-digit display; a monitor pops and compares each
//               time a conversion completes (busy falling).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_display;

   localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};
   localparam int          BUSY_CYC  = 22;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] sec = '0;
   logic [5:0] min = '0;
   logic [4:0] hr  = '0;
   logic       set_mode = 1'b0;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
   logic       busy;
   logic [41:0] disp;

   int vectors     = 0;
   int miscompares = 0;

   logic [41:0] exp_q [$];
   logic [16:0] last_val;
   bit          last_valid = 1'b0;

   always #5 clk = ~clk;

   clock_display #(
      .CLK_HZ         (8),
      .BLINK_HZ       (1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sec      (sec),
      .min      (min),
      .hr       (hr),
      .set_mode (set_mode),
      .hex0     (hex0),
      .hex1     (hex1),
      .hex2     (hex2),
      .hex3     (hex3),
      .hex4     (hex4),
      .hex5     (hex5),
      .busy     (busy)
   );

   assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

   // ---------------- reference model ----------------
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [13:0] field_ref(input int v, input int vmax);
      if (v > vmax) return {7'b0111111, 7'b0111111};
      return {seg_of(v / 10), seg_of(v % 10)};
   endfunction

   function automatic logic [41:0] display_ref(input int h, input int m, input int s);
      return {field_ref(h, 23), field_ref(m, 59), field_ref(s, 59)};
   endfunction

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Wait for every pending expectation to be consumed, bounded
   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d updates pending, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Drive a held time; a new value must produce exactly one update,
   // a repeat of the displayed value must produce none
   task automatic apply(input int h, input int m, input int s);
      logic [16:0] v;
      bit seen;
      v   = {5'(h), 6'(m), 6'(s)};
      hr  = 5'(h);
      min = 6'(m);
      sec = 6'(s);
      if (!last_valid || v != last_val) begin
         exp_q.push_back(display_ref(h, m, s));
         last_val   = v;
         last_valid = 1'b1;
         wait_drain();
      end else begin
         seen = 1'b0;
         repeat (30) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
         end
         check("no_reconvert_busy", {41'd0, seen}, 42'd0);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      bit          prev_busy;
      int          busy_len;
      logic [41:0] shown;
      logic [41:0] exp;
      prev_busy = 1'b0;
      busy_len  = 0;
      shown     = ALL_BLANK;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_busy = 1'b0;
            busy_len  = 0;
            shown     = ALL_BLANK;
         end else begin
            if (busy) begin
               busy_len++;
               check("hold_during_busy", disp, shown);
            end else if (prev_busy) begin
               check("busy_len", 42'(busy_len), 42'(BUSY_CYC));
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_update: got %h, required no update", disp);
                  shown = disp;
               end else begin
                  exp = exp_q.pop_front();
                  check("display", disp, exp);
                  shown = exp;
               end
               busy_len = 0;
            end
            prev_busy = busy;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int g, prev_g, n;
      bit blank;
      logic [41:0] shown_ref;

      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_hex", disp, ALL_BLANK);
      check("reset_busy", {41'd0, busy}, 42'd0);
      rst = 1'b1;

      // Directed values
      apply(0, 0, 0);
      apply(23, 59, 58);
      apply(12, 34, 60);
      apply(12, 34, 60);
      apply(31, 63, 5);
      apply(9, 60, 59);
      apply(24, 0, 0);

      // Random values, including out-of-range fields
      for (int i = 0; i < 16; i++) begin
         apply(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 63)));
      end

      // Glitching seconds never starts a conversion until two equal samples
      apply(5, 6, 30);
      prev_g = 30;
      for (int i = 0; i < 10; i++) begin
         do g = int'($urandom_range(0, 63)); while (g == prev_g);
         sec = 6'(g);
         prev_g = g;
         @(negedge clk);
         check("glitch_busy", {41'd0, busy}, 42'd0);
      end
      apply(5, 6, 7);

      // Blink: 4 cycles shown, 4 blank after the 2-flop synchronizer
      apply(1, 2, 3);
      shown_ref = display_ref(1, 2, 3);
      set_mode = 1'b1;
      for (int j = 1; j <= 24; j++) begin
         @(negedge clk);
         blank = (j >= 2) && (((j - 2) / 4) % 2 == 1);
         check("blink", disp, blank ? {{4{7'b1111111}}, shown_ref[13:0]} : shown_ref);
      end
      set_mode = 1'b0;
      repeat (3) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         check("blink_off", disp, shown_ref);
      end

      // Reset in the middle of a conversion
      hr  = 5'd8;
      min = 6'd9;
      sec = 6'd10;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("abort_busy_start", {41'd0, busy}, 42'd1);
      repeat (9) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_hex", disp, ALL_BLANK);
      check("abort_busy", {41'd0, busy}, 42'd0);
      last_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      apply(8, 9, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global bound on run time
   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule : tb_clock_display
`default_nettype wire

// File: doc/clock_display.md
Name: clock_display

Overview:
- Display-side consumer of the time-of-day counter's sec/min/hr outputs.
- Converts each binary field to two BCD digits with a sequential double-dabble engine and drives six 7-segment digits: hex5..hex4 = hours, hex3..hex2 = minutes, hex1..hex0 = seconds.
- Tolerates inputs that change asynchronously to clk, flags out-of-range values, and blinks the settable fields while the clock is in set mode.

Parameters:
- CLK_HZ, 50_000_000: clk frequency.
- BLINK_HZ, 2: full blink cycles per second in set mode.
- SEG_ACTIVE_LOW, 1: 1 = segment lit by 0; 0 = lit by 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- sec  in  6  seconds, binary, nominal 0..59, asynchronous to clk
- min  in  6  minutes, binary, nominal 0..59, asynchronous to clk
- hr  in  5  hours, binary, nominal 0..23, asynchronous to clk
- set_mode  in  1  1 = clock in set mode, asynchronous to clk
- hex0..hex5  out  7 each  segments {g,f,e,d,c,b,a}
- busy  out  1  conversion in progress

Behaviour:
- Reset and clock: reset is rst, synchronous, active-low; clock is clk.
- Reset state:
  - All hex outputs = blank (all segments off).
  - busy = 0; FSM = IDLE; blink counter = 0; blink phase = on.
  - Last-displayed snapshot marked invalid, so the first stable sample always converts.
- Input capture:
  - The 17-bit {hr,min,sec} is registered every cycle into s_cur, with the previous value held in s_prev.
  - A sample is stable when s_cur == s_prev.
  - set_mode passes through a 2-flop synchronizer.
- Conversion trigger: in IDLE, a stable sample that differs from the last-displayed snapshot (or any sample while the snapshot is invalid) latches into the work register and moves the FSM to CONV_SEC. Call this cycle A.
- FSM: IDLE -> CONV_SEC -> CONV_MIN -> CONV_HR -> UPDATE -> IDLE.
  - Each CONV state pulses start to the converter for 1 cycle and waits for done.
  - A conversion is exactly 7 cycles: 1 load + 6 shift/add-3 iterations. hr is zero-extended to 6 bits.
- Latency:
  - busy = 1 from cycle A+1 through UPDATE, 22 cycles.
  - hex outputs change at cycle A+23.
  - In UPDATE, all six hex output registers load simultaneously, and the snapshot is updated and marked valid.
- Input changes during a conversion are ignored. After returning to IDLE, a new stable differing sample starts another conversion. No partial updates ever reach the display.
- Range check, per field (sec > 59, min > 59, hr > 23):
  - Both digits of the offending field display dash (segment g only).
  - Other fields display normally.
  - Out-of-range values are still converted; they are substituted at UPDATE.
- Leading zeros are shown, e.g. 5 -> "05".
- Segment codes, active-low, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Dash = 0111111; blank = 1111111. Invert all codes when SEG_ACTIVE_LOW = 0.
- Blink:
  - While synced set_mode = 1, the counter counts 0..CLK_HZ/(2*BLINK_HZ)-1 and toggles the phase on wrap.
  - In the off phase, hex5..hex2 are forced blank; hex1..hex0 are never blanked.
  - When set_mode = 0, the counter is held at 0 and the phase is on.
  - Blanking is applied combinationally after the output registers, so it does not disturb conversion.
- Reset mid-conversion: on the next clk edge, outputs are blank and busy = 0. The converter abandons its work with no done pulse.

Decomposition:
- Package clock_display_pkg holds:
  - the state enum {IDLE, CONV_SEC, CONV_MIN, CONV_HR, UPDATE};
  - SEG_DIGIT[0:9], SEG_DASH, SEG_BLANK;
  - SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 23;
  - BCD_ITER = 6.
- Sub-module bin2bcd_seq:
  - Ports: clk, rst, start, bin[5:0] -> done (1-cycle pulse), tens[3:0], ones[3:0].
  - Latency 7 cycles; start while busy is ignored.

Test Plan:
1. Reset, then hr=0, min=0, sec=0 held -> busy high for exactly 22 cycles; at A+23 all hex = 1000000.
2. hr=23, min=59, sec=58 -> hex5..hex0 = 0100100, 0110000, 0010010, 0010000, 0010010, 0000000.
3. hr=12, min=34, sec=60 -> hex1 = hex0 = 0111111; hex5..hex2 = 1111001, 0100100, 0110000, 0011001.
4. sec random every cycle for 10 cycles, then held at 7 -> no conversion starts until two equal samples; final hex0 = 1111000, hex1 = 1000000.
5. CLK_HZ=8, BLINK_HZ=1, set_mode=1, display showing 01:02:03 -> hex5..hex2 alternate 4 cycles shown / 4 cycles blank (1111111); hex1..hex0 constant; set_mode=0 -> always shown.
6. rst low at cycle A+10 of a conversion -> next cycle all hex = 1111111, busy = 0; after rst returns high, a fresh conversion of the held input completes normally.
